// File: rtl/mant_arb_pkg.sv
// Shared types and constants for the FP-lane mantissa adder arbiter.
// Pipeline bundles are sized for up to eight requesters.
package mant_arb_pkg;

    localparam int MANT_W      = 23;
    localparam int NUM_REQ_DEF = 4;
    localparam int ID_W_MAX    = 3;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic [ID_W_MAX-1:0] id;
        logic [MANT_W-1:0]   a;
        logic [MANT_W-1:0]   b;
    } s1_t;

    typedef struct packed {
        logic [ID_W_MAX-1:0] id;
        logic [MANT_W-1:0]   sum;
        logic                cout;
    } s2_t;

endpackage

// File: rtl/csa_23b.sv
// 23-bit carry-select mantissa adder used by the lane arbiter.
// Upper 11 bits are computed for both carry-ins and picked by the low carry.
module CSA_23b (
    input  logic [22:0] a,
    input  logic [22:0] b,
    output logic [22:0] sum,
    output logic        cout
);

    logic [12:0] lo;
    logic [11:0] hi0;
    logic [11:0] hi1;
    logic [11:0] hi;

    assign lo  = {1'b0, a[11:0]} + {1'b0, b[11:0]};
    assign hi0 = {1'b0, a[22:12]} + {1'b0, b[22:12]};
    assign hi1 = {1'b0, a[22:12]} + {1'b0, b[22:12]} + 12'd1;
    assign hi  = lo[12] ? hi1 : hi0;

    assign sum  = {hi[10:0], lo[11:0]};
    assign cout = hi[11];

endmodule

// File: rtl/mant_adder_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: scans from ptr upward with wrap.
// Reusable by other lane schedulers; gnt is one-hot or zero.
module rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    input  logic           en,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id
);

    logic found;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        if (en) begin
            for (int k = 0; k < N; k++) begin
                for (int j = 0; j < N; j++) begin
                    if (!found && req[j] &&
                        j == ((int'(ptr) + k) % N)) begin
                        found  = 1'b1;
                        gnt[j] = 1'b1;
                        gnt_id = IDW'(j);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/mant_adder_arbiter.sv
// Shares one CSA_23b among NUM_REQ requesters: round-robin grant,
// operand register (S1), adder, result register (S2), valid/ready out.
module mant_adder_arbiter
    import mant_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*MANT_W-1:0] req_a,
    input  logic [NUM_REQ*MANT_W-1:0] req_b,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [ID_W-1:0]           resp_id,
    output logic [MANT_W-1:0]         resp_sum,
    output logic                      resp_cout,
    output logic                      busy
);

    s1_t               s1_q, s1_d;
    s2_t               s2_q, s2_d;
    logic              s1_valid_q, s1_valid_d;
    logic              s2_valid_q, s2_valid_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;

    logic              s1_adv;
    logic              s2_adv;
    logic              arb_en;
    logic              transfer;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]   gnt_id;
    logic [MANT_W-1:0] sel_a;
    logic [MANT_W-1:0] sel_b;
    logic [MANT_W-1:0] csa_sum;
    logic              csa_cout;

    always_comb begin
        s2_adv = !s2_valid_q || resp_ready;
        s1_adv = !s1_valid_q || s2_adv;
    end

    // Reset gates the grant so req_ready stays low while rst_n is held.
    assign arb_en = s1_adv && rst_n;

    rr_arbiter #(
        .N   (NUM_REQ),
        .IDW (ID_W)
    ) u_arb (
        .req    (req_valid),
        .ptr    (rr_ptr_q),
        .en     (arb_en),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    assign transfer = |gnt;

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_a = sel_a | req_a[i*MANT_W +: MANT_W];
                sel_b = sel_b | req_b[i*MANT_W +: MANT_W];
            end
        end
    end

    CSA_23b u_csa (
        .a    (s1_q.a),
        .b    (s1_q.b),
        .sum  (csa_sum),
        .cout (csa_cout)
    );

    always_comb begin
        s1_d       = s1_q;
        s2_d       = s2_q;
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        rr_ptr_d   = rr_ptr_q;

        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            s2_d.id    = s1_q.id;
            s2_d.sum   = csa_sum;
            s2_d.cout  = csa_cout;
        end

        if (s1_adv) begin
            s1_valid_d = transfer;
            if (transfer) begin
                s1_d.id = ID_W_MAX'(gnt_id);
                s1_d.a  = sel_a;
                s1_d.b  = sel_b;
            end
        end

        if (transfer) begin
            if (gnt_id == ID_W'(NUM_REQ - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = gnt_id + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q       <= '0;
            s2_q       <= '0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            rr_ptr_q   <= '0;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign req_ready  = gnt;
    assign resp_valid = s2_valid_q;
    assign resp_id    = ID_W'(s2_q.id);
    assign resp_sum   = s2_q.sum;
    assign resp_cout  = s2_q.cout;
    assign busy       = s1_valid_q || s2_valid_q;

endmodule

// File: tb/tb_mant_adder_arbiter.sv
// Scoreboard bench for mant_adder_arbiter (4-requester and 3-requester
// instances): expected results queued at grant, popped at response.
module tb_mant_adder_arbiter;

    typedef struct packed {
        logic [1:0]  id;
        logic [22:0] sum;
        logic        cout;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [91:0]  req_a;
    logic [91:0]  req_b;
    logic         resp_valid;
    logic         resp_ready;
    logic [1:0]   resp_id;
    logic [22:0]  resp_sum;
    logic         resp_cout;
    logic         busy;

    logic [2:0]   req_valid3;
    logic [2:0]   req_ready3;
    logic [68:0]  req_a3;
    logic [68:0]  req_b3;
    logic         resp_valid3;
    logic         resp_ready3;
    logic [1:0]   resp_id3;
    logic [22:0]  resp_sum3;
    logic         resp_cout3;
    logic         busy3;

    int checks = 0;
    int errors = 0;

    exp_t sb[$];
    int   gnt_log[$];
    int   n_resp = 0;
    int   n_acc  = 0;

    logic       m_s1v, m_s2v;
    int         m_ptr;
    logic       have_prev;
    logic       p_valid, p_ready;
    logic [1:0] p_id;
    logic [22:0] p_sum;
    logic       p_cout;

    mant_adder_arbiter #(
        .NUM_REQ (4),
        .ID_W    (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_sum   (resp_sum),
        .resp_cout  (resp_cout),
        .busy       (busy)
    );

    mant_adder_arbiter #(
        .NUM_REQ (3),
        .ID_W    (2)
    ) dut3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid3),
        .req_ready  (req_ready3),
        .req_a      (req_a3),
        .req_b      (req_b3),
        .resp_valid (resp_valid3),
        .resp_ready (resp_ready3),
        .resp_id    (resp_id3),
        .resp_sum   (resp_sum3),
        .resp_cout  (resp_cout3),
        .busy       (busy3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic exp_t mk_exp(input int id,
                                    input logic [22:0] a,
                                    input logic [22:0] b);
        exp_t e;
        logic [23:0] s;
        s      = {1'b0, a} + {1'b0, b};
        e.id   = 2'(id);
        e.sum  = s[22:0];
        e.cout = s[23];
        return e;
    endfunction

    // Reference model: pipeline occupancy, pointer, scoreboard.
    always @(negedge clk) begin
        logic s1a, s2a, f;
        logic [3:0] eg;
        exp_t e;
        int idx;
        if (!rst_n) begin
            m_s1v = 1'b0;
            m_s2v = 1'b0;
            m_ptr = 0;
            have_prev = 1'b0;
            sb.delete();
        end else begin
            s2a = !m_s2v || resp_ready;
            s1a = !m_s1v || s2a;
            eg = '0;
            f = 1'b0;
            if (s1a) begin
                for (int k = 0; k < 4; k++) begin
                    idx = (m_ptr + k) % 4;
                    if (!f && req_valid[idx]) begin
                        f = 1'b1;
                        eg[idx] = 1'b1;
                    end
                end
            end
            checks++;
            if (req_ready !== eg) begin
                errors++;
                $display("FAIL grant: req_ready=%b expected %b", req_ready, eg);
            end
            checks++;
            if (resp_valid !== m_s2v) begin
                errors++;
                $display("FAIL resp_valid: got %b expected %b", resp_valid, m_s2v);
            end
            checks++;
            if (busy !== (m_s1v | m_s2v)) begin
                errors++;
                $display("FAIL busy: got %b expected %b", busy, m_s1v | m_s2v);
            end
            if (have_prev && p_valid && !p_ready) begin
                checks++;
                if (resp_valid !== 1'b1 || resp_id !== p_id ||
                    resp_sum !== p_sum || resp_cout !== p_cout) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%b id=%0d sum=%h c=%b expected v=1 id=%0d sum=%h c=%b",
                             resp_valid, resp_id, resp_sum, resp_cout, p_id, p_sum, p_cout);
                end
            end
            if (resp_valid && resp_ready) begin
                n_resp++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_pop: unexpected result id=%0d sum=%h, expected none",
                             resp_id, resp_sum);
                end else begin
                    e = sb.pop_front();
                    if (resp_id !== e.id || resp_sum !== e.sum || resp_cout !== e.cout) begin
                        errors++;
                        $display("FAIL result: got id=%0d sum=%h c=%b expected id=%0d sum=%h c=%b",
                                 resp_id, resp_sum, resp_cout, e.id, e.sum, e.cout);
                    end
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    sb.push_back(mk_exp(i, req_a[i*23 +: 23], req_b[i*23 +: 23]));
                    gnt_log.push_back(i);
                    n_acc++;
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (eg[i]) m_ptr = (i + 1) % 4;
            end
            if (s2a) m_s2v = m_s1v;
            if (s1a) m_s1v = |eg;
            have_prev = 1'b1;
            p_valid = resp_valid;
            p_ready = resp_ready;
            p_id = resp_id;
            p_sum = resp_sum;
            p_cout = resp_cout;
        end
    end

    task automatic set_ops(input int i, input logic [22:0] a,
                           input logic [22:0] b);
        req_a[i*23 +: 23] = a;
        req_b[i*23 +: 23] = b;
    endtask

    task automatic step(input bit rand_ops);
        logic [3:0] hs;
        @(negedge clk);
        hs = req_valid & req_ready;
        @(posedge clk);
        #1;
        if (rand_ops) begin
            for (int i = 0; i < 4; i++) begin
                if (hs[i]) set_ops(i, 23'($urandom), 23'($urandom));
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        req_valid3 = '0;
        resp_ready = 1'b1;
        resp_ready3 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drain();
        req_valid = '0;
        resp_ready = 1'b1;
        for (int c = 0; c < 30 && (sb.size() != 0 || busy); c++) step(0);
        checks++;
        if (sb.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL drain: pending=%0d busy=%b, expected 0 and 0", sb.size(), busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_a = '0;
        req_b = '0;
        req_a3 = '0;
        req_b3 = '0;
        req_valid = 4'hF;
        req_valid3 = '0;
        resp_ready = 1'b1;
        resp_ready3 = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (resp_valid !== 1'b0 || resp_id !== 2'd0 || resp_sum !== 23'd0 ||
            resp_cout !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0) begin
            errors++;
            $display("FAIL reset_outs: v=%b id=%0d sum=%h c=%b busy=%b rdy=%b expected all 0",
                     resp_valid, resp_id, resp_sum, resp_cout, busy, req_ready);
        end
        req_valid = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        set_ops(0, 23'h000005, 23'h000003);
        req_valid = 4'b0001;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL single_ready: got %b expected 0001", req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_early: resp_valid=%b expected 0", resp_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (resp_valid !== 1'b1 || resp_id !== 2'd0 ||
            resp_sum !== 23'h000008 || resp_cout !== 1'b0) begin
            errors++;
            $display("FAIL single_result: v=%b id=%0d sum=%h c=%b expected 1 0 000008 0",
                     resp_valid, resp_id, resp_sum, resp_cout);
        end
        drain();
    endtask

    task automatic test_carry();
        set_ops(2, 23'h7FFFFF, 23'h000001);
        req_valid = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL carry_ready: got %b expected 0100", req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        @(posedge clk);
        #1;
        checks++;
        if (resp_valid !== 1'b1 || resp_id !== 2'd2 ||
            resp_sum !== 23'h000000 || resp_cout !== 1'b1) begin
            errors++;
            $display("FAIL carry_result: v=%b id=%0d sum=%h c=%b expected 1 2 000000 1",
                     resp_valid, resp_id, resp_sum, resp_cout);
        end
        drain();
    endtask

    task automatic test_fairness();
        int n0;
        do_reset();
        for (int i = 0; i < 4; i++) set_ops(i, 23'($urandom), 23'($urandom));
        req_valid = 4'hF;
        resp_ready = 1'b1;
        gnt_log.delete();
        n0 = n_resp;
        repeat (12) step(1);
        req_valid = '0;
        checks++;
        if (gnt_log.size() != 12) begin
            errors++;
            $display("FAIL fair_count: grants=%0d expected 12", gnt_log.size());
        end
        for (int k = 0; k < gnt_log.size(); k++) begin
            checks++;
            if (gnt_log[k] != k % 4) begin
                errors++;
                $display("FAIL fair_order[%0d]: got %0d expected %0d", k, gnt_log[k], k % 4);
            end
        end
        checks++;
        if (n_resp - n0 != 10) begin
            errors++;
            $display("FAIL fair_rate: results=%0d expected 10", n_resp - n0);
        end
        drain();
    endtask

    task automatic test_backpressure();
        int a0, r0;
        a0 = n_acc;
        r0 = n_resp;
        set_ops(1, 23'($urandom), 23'($urandom));
        req_valid = 4'b0010;
        resp_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c >= 2) begin
                checks++;
                if (req_ready !== 4'b0 || resp_valid !== 1'b1 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_full[%0d]: rdy=%b v=%b busy=%b expected 0000 1 1",
                             c, req_ready, resp_valid, busy);
                end
            end
            step(1);
        end
        resp_ready = 1'b1;
        repeat (8) step(1);
        drain();
        checks++;
        if (n_acc - a0 != n_resp - r0 || n_acc - a0 < 8) begin
            errors++;
            $display("FAIL bp_count: accepted=%0d returned=%0d expected equal and >=8",
                     n_acc - a0, n_resp - r0);
        end
    endtask

    task automatic test_random();
        logic [3:0] hs;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            hs = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (hs[i]) set_ops(i, 23'($urandom), 23'($urandom));
                if (hs[i] || !req_valid[i]) req_valid[i] = 1'($urandom);
            end
            resp_ready = ($urandom % 4) != 0;
        end
        drain();
    endtask

    task automatic test_reset_midflight();
        for (int i = 0; i < 4; i++) set_ops(i, 23'($urandom), 23'($urandom));
        req_valid = 4'hF;
        resp_ready = 1'b0;
        step(1);
        step(1);
        checks++;
        if (resp_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_fill: v=%b busy=%b expected 1 1", resp_valid, busy);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (resp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0) begin
            errors++;
            $display("FAIL mid_async: v=%b busy=%b rdy=%b expected 0 0 0000",
                     resp_valid, busy, req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = 4'b1010;
        resp_ready = 1'b1;
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL mid_first_grant: got %b expected 0010", req_ready);
        end
        repeat (4) step(1);
        drain();
    endtask

    task automatic test_pointer_wrap();
        exp_t q3[$];
        exp_t e;
        int gid, exp_id, nb;
        do_reset();
        req_a3[0*23 +: 23] = 23'h000100;
        req_b3[0*23 +: 23] = 23'h000023;
        req_a3[2*23 +: 23] = 23'h7FFFFF;
        req_b3[2*23 +: 23] = 23'h7FFFFF;
        req_valid3 = 3'b101;
        resp_ready3 = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (c == 10) req_valid3 = '0;
            if (resp_valid3) begin
                checks++;
                if (q3.size() == 0) begin
                    errors++;
                    $display("FAIL wrap_pop: unexpected id=%0d, expected none", resp_id3);
                end else begin
                    e = q3.pop_front();
                    if (resp_id3 !== e.id || resp_sum3 !== e.sum || resp_cout3 !== e.cout) begin
                        errors++;
                        $display("FAIL wrap_result: got id=%0d sum=%h c=%b expected id=%0d sum=%h c=%b",
                                 resp_id3, resp_sum3, resp_cout3, e.id, e.sum, e.cout);
                    end
                end
            end
            checks++;
            if (dut3.rr_ptr_q > 2'd2) begin
                errors++;
                $display("FAIL wrap_ptr: rr_ptr=%0d expected <3", dut3.rr_ptr_q);
            end
            if (c < 10) begin
                gid = -1;
                nb = 0;
                for (int i = 0; i < 3; i++) begin
                    if (req_ready3[i]) begin
                        gid = i;
                        nb++;
                    end
                end
                exp_id = (c % 2 == 0) ? 0 : 2;
                checks++;
                if (nb != 1 || gid != exp_id) begin
                    errors++;
                    $display("FAIL wrap_grant[%0d]: rdy=%b expected id %0d", c, req_ready3, exp_id);
                end
                if (gid >= 0) q3.push_back(mk_exp(gid, req_a3[gid*23 +: 23], req_b3[gid*23 +: 23]));
            end
        end
        checks++;
        if (q3.size() != 0 || busy3 !== 1'b0) begin
            errors++;
            $display("FAIL wrap_drain: pending=%0d busy=%b expected 0 0", q3.size(), busy3);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_carry();
        test_fairness();
        test_backpressure();
        test_random();
        test_reset_midflight();
        test_pointer_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
